// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter slice.
//   owner_e : records which port owns the read data that returns next cycle
//   WORD_W  : RAM word width in bits
//   RAM_AW  : default byte-address width (512-byte unified RAM)
package cpu_pkg;

    localparam int WORD_W = 32;
    localparam int RAM_AW = 9;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_prio.sv
// arb_prio: combinational grant selector for the shared RAM port.
// Ports:
//   if_req, d_req : requests, already masked by reset in the parent
//   force_if      : fetch has starved long enough and must win this cycle
//   if_gnt, d_gnt : one-hot-or-zero grants
// The data port wins a conflict unless force_if is set.
module arb_prio (
    input  logic if_req,
    input  logic d_req,
    input  logic force_if,
    output logic if_gnt,
    output logic d_gnt
);

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (if_req && (!d_req || force_if)) begin
            if_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous 32-bit-wide RAM between the
// instruction-fetch port and the MEM-stage load/store port.
// Ports:
//   clka, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr/if_gnt            fetch request and combinational grant
//   if_rvalid/if_rdata               fetch read return, one cycle after grant
//   d_req/d_we/d_addr/d_wdata/d_gnt  load/store request and grant
//   d_rvalid/d_rdata                 load read return (never for stores)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   RAM port
//   stall_if                         fetch requested but was not granted
//   misalign_err                     sticky: a misaligned access was consumed
// Build option: define MEM_PORT_ARBITER_FAIR_EN to add the fetch starvation
// counter; otherwise the data port has strict priority.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = RAM_AW,
    parameter int STARVE_MAX = 4
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [WORD_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              misalign_err
);

    logic if_req_v;
    logic d_req_v;
    logic force_if;

    // Masking the requests makes every grant zero while reset is held.
    assign if_req_v = if_req & rst_n;
    assign d_req_v  = d_req & rst_n;

    arb_prio u_arb_prio (
        .if_req   (if_req_v),
        .d_req    (d_req_v),
        .force_if (force_if),
        .if_gnt   (if_gnt),
        .d_gnt    (d_gnt)
    );

    assign stall_if = if_req_v & ~if_gnt;

`ifdef MEM_PORT_ARBITER_FAIR_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    assign force_if = (starve_q == STARVE_TOP);

    always_comb begin
        starve_d = '0;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    owner_e            owner_q, owner_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] if_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;
    logic [WORD_W-1:0] ret_data;

    // Grant decode: drive the RAM for aligned accesses only, and remember
    // who owns the read data (stores own nothing) and whether it must read 0.
    always_comb begin
        owner_d   = OWN_NONE;
        mis_d     = 1'b0;
        err_d     = err_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (if_gnt) begin
            owner_d = OWN_IF;
            if (if_addr[1:0] == 2'b00) begin
                ram_en   = 1'b1;
                ram_addr = {if_addr[AW-1:2], 2'b00};
            end else begin
                mis_d = 1'b1;
                err_d = 1'b1;
            end
        end else if (d_gnt) begin
            owner_d = d_we ? OWN_NONE : OWN_D;
            if (d_addr[1:0] == 2'b00) begin
                ram_en    = 1'b1;
                ram_we    = d_we;
                ram_addr  = {d_addr[AW-1:2], 2'b00};
                ram_wdata = d_wdata;
            end else begin
                mis_d = 1'b1;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q <= owner_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            if (owner_q == OWN_IF) begin
                if_rdata_q <= ret_data;
            end
            if (owner_q == OWN_D) begin
                d_rdata_q <= ret_data;
            end
        end
    end

    assign ret_data = mis_q ? '0 : ram_rdata;

    // Returns are gated by rst_n so a reset in the return cycle discards
    // the pending read immediately rather than one cycle later.
    assign if_rvalid    = rst_n & (owner_q == OWN_IF);
    assign d_rvalid     = rst_n & (owner_q == OWN_D);
    assign if_rdata     = !rst_n ? '0 : (owner_q == OWN_IF) ? ret_data : if_rdata_q;
    assign d_rdata      = !rst_n ? '0 : (owner_q == OWN_D) ? ret_data : d_rdata_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 9;

    logic          clka = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = 32'h0;
    logic          stall_if;
    logic          misalign_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:127];

    mem_port_arbiter #(.AW(AW), .STARVE_MAX(4)) dut (
        .clka         (clka),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .stall_if     (stall_if),
        .misalign_err (misalign_err)
    );

    always #5 clka = ~clka;

    // Synchronous RAM behind the port.
    always @(posedge clka) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[AW-1:2]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[AW-1:2]];
        end
    end

    task automatic next_cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        if_req = 1'b1; d_req = 1'b1; d_addr = 9'h020;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL reset_if_gnt got=%b exp=0", if_gnt); end
        checks++; if (d_gnt !== 1'b0) begin failures++; $display("FAIL reset_d_gnt got=%b exp=0", d_gnt); end
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_en_we got=%b%b exp=00", ram_en, ram_we); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_if); end
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata); end
        checks++; if (ram_addr !== '0 || ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_bus got=%h/%h exp=0", ram_addr, ram_wdata); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch_only();
        if_req = 1'b1; if_addr = 9'h010;
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL fetch_gnt got=%b exp=1", if_gnt); end
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'h010) begin failures++; $display("FAIL fetch_ram got en=%b we=%b addr=%h exp en=1 we=0 addr=010", ram_en, ram_we, ram_addr); end
        checks++; if (stall_if !== 1'b0) begin failures++; $display("FAIL fetch_stall got=%b exp=0", stall_if); end
        next_cycle();
        if_req = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h8C0E0000) begin failures++; $display("FAIL fetch_return got v=%b d=%h exp v=1 d=8c0e0000", if_rvalid, if_rdata); end
        checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_no_drvalid got=%b exp=0", d_rvalid); end
        next_cycle();
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h8C0E0000) begin failures++; $display("FAIL fetch_hold got v=%b d=%h exp v=0 d=8c0e0000", if_rvalid, if_rdata); end
    endtask

    task automatic test_conflict();
        if_req = 1'b1; if_addr = 9'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020;
        #1;
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin failures++; $display("FAIL conflict_gnt got d=%b if=%b exp d=1 if=0", d_gnt, if_gnt); end
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL conflict_stall got=%b exp=1", stall_if); end
        checks++; if (ram_addr !== 9'h020 || ram_en !== 1'b1) begin failures++; $display("FAIL conflict_ram_addr got=%h en=%b exp=020 en=1", ram_addr, ram_en); end
        next_cycle();
        d_req = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin failures++; $display("FAIL conflict_dret got v=%b d=%h exp v=1 d=12345678", d_rvalid, d_rdata); end
        checks++; if (if_gnt !== 1'b1 || stall_if !== 1'b0) begin failures++; $display("FAIL conflict_if_gnt got gnt=%b stall=%b exp 1/0", if_gnt, stall_if); end
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h8C0E0000) begin failures++; $display("FAIL conflict_if_hold got v=%b d=%h exp v=0 d=8c0e0000", if_rvalid, if_rdata); end
        next_cycle();
        if_req = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || d_rdata !== 32'h12345678) begin failures++; $display("FAIL conflict_if_ret got iv=%b dv=%b dd=%h exp 1/0/12345678", if_rvalid, d_rvalid, d_rdata); end
        next_cycle();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h0F0; d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (d_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin failures++; $display("FAIL store_port got gnt=%b en=%b we=%b exp 111", d_gnt, ram_en, ram_we); end
        checks++; if (ram_addr !== 9'h0F0 || ram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_bus got a=%h w=%h exp 0f0/deadbeef", ram_addr, ram_wdata); end
        next_cycle();
        d_we = 1'b0; d_wdata = '0;
        #1;
        checks++; if (d_rvalid !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got=%b exp=0", d_rvalid); end
        checks++; if (d_gnt !== 1'b1 || ram_we !== 1'b0) begin failures++; $display("FAIL load_gnt got gnt=%b we=%b exp 1/0", d_gnt, ram_we); end
        next_cycle();
        d_req = 1'b0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_back got v=%b d=%h exp v=1 d=deadbeef", d_rvalid, d_rdata); end
        next_cycle();
    endtask

    task automatic test_misaligned();
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h003;
        #1;
        checks++; if (d_gnt !== 1'b1 || ram_en !== 1'b0) begin failures++; $display("FAIL mis_gnt got gnt=%b en=%b exp 1/0", d_gnt, ram_en); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_err_early got=%b exp=0", misalign_err); end
        next_cycle();
        d_req = 1'b0; d_addr = '0;
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL mis_ret got v=%b d=%h exp v=1 d=0", d_rvalid, d_rdata); end
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_err_set got=%b exp=1", misalign_err); end
        next_cycle();
        next_cycle();
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_err_held got=%b exp=1", misalign_err); end
    endtask

    task automatic test_starvation();
        logic exp_gnt;
        if_req = 1'b1; if_addr = 9'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            #1;
`ifdef MEM_PORT_ARBITER_FAIR_EN
            exp_gnt = (cyc == 5 || cyc == 10);
`else
            exp_gnt = 1'b0;
`endif
            checks++;
            if (if_gnt !== exp_gnt || d_gnt !== !exp_gnt) begin
                failures++;
                $display("FAIL starve_cyc%0d got if=%b d=%b exp if=%b d=%b", cyc, if_gnt, d_gnt, exp_gnt, !exp_gnt);
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 9'h010;
        #1;
        checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL rstmid_gnt got=%b exp=1", if_gnt); end
        next_cycle();
        if_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rvalid got v=%b d=%h exp v=0 d=0", if_rvalid, if_rdata); end
        next_cycle();
        checks++; if (misalign_err !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_state got err=%b iv=%b dv=%b exp 000", misalign_err, if_rvalid, d_rvalid); end
        checks++; if (d_rdata !== 32'h0 || ram_en !== 1'b0 || stall_if !== 1'b0) begin failures++; $display("FAIL rstmid_outs got dd=%h en=%b st=%b exp 0/0/0", d_rdata, ram_en, stall_if); end
        rst_n = 1'b1;
        next_cycle();
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_discard got v=%b d=%h exp v=0 d=0", if_rvalid, if_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[9'h010 >> 2] = 32'h8C0E0000;
        mem[9'h020 >> 2] = 32'h12345678;
        test_reset();
        test_fetch_only();
        test_conflict();
        test_store_load();
        test_misaligned();
        test_starvation();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
